// File: rtl/load_store_pkg.sv
// rtl/load_store_pkg.sv - size/state encodings and lane-select helper for the load/store unit
package load_store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOAD_WAIT = 2'b01,
    ST_RMW       = 2'b10
  } state_t;

  // Bit position of the lane's LSB within the 32-bit word.
  function automatic logic [4:0] lane_shift(input logic [1:0] off, input logic [1:0] size,
                                            input logic big_endian);
    logic [4:0] s;
    s = 5'd0;
    if (size == SZ_BYTE) begin
      s = big_endian ? (5'd24 - {off, 3'b000}) : {off, 3'b000};
    end else if (size == SZ_HALF) begin
      s = big_endian ? (5'd16 - {off, 3'b000}) : {off, 3'b000};
    end
    return s;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signals of the load/store unit
interface load_store_unit_if #(parameter int ADDR_WIDTH = 7);
  logic                  req_valid;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  req_ready;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  store_done;
  logic                  misalign;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [31:0]           mem_write_data;
  logic [31:0]           mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, store_done, misalign,
           mem_address, mem_read, mem_write, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, store_done, misalign,
           mem_address, mem_read, mem_write, mem_write_data
  );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - load lane extract/extend and sub-word store merge
module lsu_lane_align
  import load_store_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [4:0]  w_shift;
  logic [31:0] w_lane;
  logic [31:0] w_mask_lo;

  assign w_shift = lane_shift(i_off, i_size, BIG_ENDIAN);
  assign w_lane  = i_word >> w_shift;

  always_comb begin
    o_load_data = i_word;
    w_mask_lo   = 32'hFFFF_FFFF;
    if (i_size == SZ_BYTE) begin
      o_load_data = {{24{~i_unsigned & w_lane[7]}}, w_lane[7:0]};
      w_mask_lo   = 32'h0000_00FF;
    end else if (i_size == SZ_HALF) begin
      o_load_data = {{16{~i_unsigned & w_lane[15]}}, w_lane[15:0]};
      w_mask_lo   = 32'h0000_FFFF;
    end
  end

  // Store data is right-justified; move its low lane into place over the old word.
  assign o_merged = (i_word & ~(w_mask_lo << w_shift)) | ((i_wdata & w_mask_lo) << w_shift);

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage controller driving a word-addressed synchronous-read data memory
module load_store_unit
  import load_store_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_off;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [31:0]           r_wdata;
  logic                  r_resp_valid;
  logic [31:0]           r_resp_rdata;
  logic                  r_store_done;
  logic                  r_misalign;

  logic                  w_aligned;
  logic                  w_accept;
  logic                  w_word_store;
  logic [31:0]           w_load_data;
  logic [31:0]           w_merged;

  always_comb begin
    w_aligned = 1'b1;
    case (bus.req_size)
      SZ_HALF: w_aligned = ~bus.req_addr[0];
      SZ_WORD: w_aligned = (bus.req_addr[1:0] == 2'b00);
      SZ_ILL:  w_aligned = 1'b0;
      default: w_aligned = 1'b1;
    endcase
  end

  assign w_accept     = (r_state == ST_IDLE) && bus.req_valid && w_aligned;
  assign w_word_store = bus.req_write && (bus.req_size == SZ_WORD);

  // Loads and sub-word stores both start with a read; only word stores write directly.
  assign bus.mem_read       = ~reset && w_accept && ~w_word_store;
  assign bus.mem_write      = ~reset && ((w_accept && w_word_store) || (r_state == ST_RMW));
  assign bus.mem_address    = (r_state == ST_IDLE) ? bus.req_addr[ADDR_WIDTH+1:2] : r_addr;
  assign bus.mem_write_data = (r_state == ST_RMW) ? w_merged : bus.req_wdata;

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.store_done = r_store_done;
  assign bus.misalign   = r_misalign;

  lsu_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .i_word      (bus.mem_read_data),
    .i_off       (r_off),
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_off        <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_store_done <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_store_done <= 1'b0;
      r_misalign   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid && !w_aligned) begin
            r_misalign <= 1'b1;
          end else if (w_accept && w_word_store) begin
            r_store_done <= 1'b1;
          end else if (w_accept) begin
            r_addr     <= bus.req_addr[ADDR_WIDTH+1:2];
            r_off      <= bus.req_addr[1:0];
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_wdata    <= bus.req_wdata;
            r_state    <= bus.req_write ? ST_RMW : ST_LOAD_WAIT;
          end
        end
        ST_LOAD_WAIT: begin
          r_resp_rdata <= w_load_data;
          r_resp_valid <= 1'b1;
          r_state      <= ST_IDLE;
        end
        ST_RMW: begin
          r_store_done <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a behavioural data memory
module tb_load_store_unit;

  localparam int AW = 7;

  logic clk;
  logic reset;
  logic init_mem;
  logic [31:0] mem [128];

  int checks;
  int errors;

  load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();

  load_store_unit #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[5] <= 32'h8899AABB;
    end else begin
      if (bus.mem_read) bus.mem_read_data <= mem[bus.mem_address];
      if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [8:0]  addr;
    logic [31:0] wdata;
    int          kind;
    int          lat;
    logic        rd0;
    logic        wr0;
    logic        ready1;
    logic [31:0] rdata;
    logic [31:0] wd1;
    int          widx;
    logic [31:0] wval;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [8:0] addr, input logic [31:0] wdata, input int kind,
                              input int lat, input logic rd0, input logic wr0, input logic ready1,
                              input logic [31:0] rdata, input logic [31:0] wd1, input int widx,
                              input logic [31:0] wval);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.kind = kind; v.lat = lat; v.rd0 = rd0; v.wr0 = wr0; v.ready1 = ready1;
    v.rdata = rdata; v.wd1 = wd1; v.widx = widx; v.wval = wval;
    return v;
  endfunction

  task automatic run(input int n, input vec_t v);
    int   got_lat;
    logic stray;
    string tag;
    tag = $sformatf("v%0d", n);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = v.wr; bus.req_size = v.sz;
    bus.req_unsigned = v.uns; bus.req_addr = v.addr; bus.req_wdata = v.wdata;
    #1;
    chk({tag, "_rd0"}, 32'(bus.mem_read), 32'(v.rd0));
    chk({tag, "_wr0"}, 32'(bus.mem_write), 32'(v.wr0));
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk({tag, "_ready1"}, 32'(bus.req_ready), 32'(v.ready1));
    if (v.kind == 1 && v.lat == 2) begin
      chk({tag, "_rmw_wr"}, 32'(bus.mem_write), 32'd1);
      chk({tag, "_rmw_data"}, bus.mem_write_data, v.wd1);
    end
    got_lat = 0;
    stray = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (bus.mem_read && bus.mem_write) stray = 1'b1;
      case (v.kind)
        0: begin
          if (bus.resp_valid && got_lat == 0) got_lat = c;
          if (bus.store_done || bus.misalign) stray = 1'b1;
        end
        1: begin
          if (bus.store_done && got_lat == 0) got_lat = c;
          if (bus.resp_valid || bus.misalign) stray = 1'b1;
        end
        default: begin
          if (bus.misalign && got_lat == 0) got_lat = c;
          if (bus.resp_valid || bus.store_done || bus.mem_read || bus.mem_write) stray = 1'b1;
        end
      endcase
      if (c < 3) begin
        @(negedge clk);
        #1;
      end
    end
    chk({tag, "_latency"}, 32'(got_lat), 32'(v.lat));
    chk({tag, "_stray"}, 32'(stray), 32'd0);
    if (v.kind == 0) chk({tag, "_rdata"}, bus.resp_rdata, v.rdata);
    chk({tag, "_mem"}, mem[v.widx], v.wval);
  endtask

  initial begin
    logic [31:0] w5_before;
    checks = 0;
    errors = 0;
    vecs[0]  = mk(0, 2'b10, 0, 9'h014, 0,          0, 2, 1, 0, 0, 32'h8899AABB, 0, 5, 32'h8899AABB);
    vecs[1]  = mk(0, 2'b00, 0, 9'h015, 0,          0, 2, 1, 0, 0, 32'hFFFFFF99, 0, 5, 32'h8899AABB);
    vecs[2]  = mk(0, 2'b00, 1, 9'h015, 0,          0, 2, 1, 0, 0, 32'h00000099, 0, 5, 32'h8899AABB);
    vecs[3]  = mk(0, 2'b01, 1, 9'h016, 0,          0, 2, 1, 0, 0, 32'h0000AABB, 0, 5, 32'h8899AABB);
    vecs[4]  = mk(0, 2'b01, 0, 9'h014, 0,          0, 2, 1, 0, 0, 32'hFFFF8899, 0, 5, 32'h8899AABB);
    vecs[5]  = mk(1, 2'b01, 0, 9'h016, 32'h1234,   1, 2, 1, 0, 0, 0, 32'h88991234, 5, 32'h88991234);
    vecs[6]  = mk(0, 2'b10, 0, 9'h014, 0,          0, 2, 1, 0, 0, 32'h88991234, 0, 5, 32'h88991234);
    vecs[7]  = mk(0, 2'b01, 0, 9'h013, 0,          2, 1, 0, 0, 1, 0, 0, 5, 32'h88991234);
    vecs[8]  = mk(1, 2'b10, 0, 9'h016, 32'hFFFFFFFF, 2, 1, 0, 0, 1, 0, 0, 5, 32'h88991234);
    vecs[9]  = mk(0, 2'b11, 0, 9'h014, 0,          2, 1, 0, 0, 1, 0, 0, 5, 32'h88991234);
    vecs[10] = mk(1, 2'b00, 0, 9'h017, 32'hFFFFFFCC, 1, 2, 1, 0, 0, 0, 32'h889912CC, 5, 32'h889912CC);
    vecs[11] = mk(0, 2'b00, 0, 9'h017, 0,          0, 2, 1, 0, 0, 32'hFFFFFFCC, 0, 5, 32'h889912CC);
    vecs[12] = mk(1, 2'b10, 0, 9'h018, 32'hDEADBEEF, 1, 1, 0, 1, 1, 0, 0, 6, 32'hDEADBEEF);
    vecs[13] = mk(0, 2'b00, 1, 9'h018, 0,          0, 2, 1, 0, 0, 32'h000000DE, 0, 6, 32'hDEADBEEF);
    vecs[14] = mk(0, 2'b01, 0, 9'h01A, 0,          0, 2, 1, 0, 0, 32'hFFFFBEEF, 0, 6, 32'hDEADBEEF);

    reset = 1'b1;
    init_mem = 1'b1;
    bus.mem_read_data = 32'h0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 9'h014; bus.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_store_done", 32'(bus.store_done), 32'd0);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    init_mem = 1'b0;

    for (int i = 0; i < 15; i++) run(i, vecs[i]);

    // Back-to-back word stores.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 9'h000; bus.req_wdata = 32'h11111111;
    #1;
    chk("b2b_wr0", 32'(bus.mem_write), 32'd1);
    chk("b2b_addr0", 32'(bus.mem_address), 32'd0);
    @(negedge clk);
    bus.req_addr = 9'h004; bus.req_wdata = 32'h22222222;
    #1;
    chk("b2b_ready1", 32'(bus.req_ready), 32'd1);
    chk("b2b_wr1", 32'(bus.mem_write), 32'd1);
    chk("b2b_addr1", 32'(bus.mem_address), 32'd1);
    chk("b2b_done1", 32'(bus.store_done), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("b2b_done2", 32'(bus.store_done), 32'd1);
    chk("b2b_mem0", mem[0], 32'h11111111);
    chk("b2b_mem1", mem[1], 32'h22222222);

    // Reset landing in the RMW cycle of a byte store.
    w5_before = mem[5];
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
    bus.req_addr = 9'h014; bus.req_wdata = 32'h77;
    #1;
    chk("rrmw_rd0", 32'(bus.mem_read), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rrmw_wr_suppressed", 32'(bus.mem_write), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    chk("rrmw_ready", 32'(bus.req_ready), 32'd1);
    chk("rrmw_done", 32'(bus.store_done), 32'd0);
    chk("rrmw_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rrmw_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rrmw_misalign", 32'(bus.misalign), 32'd0);
    @(negedge clk);
    #1;
    chk("rrmw_done_late", 32'(bus.store_done), 32'd0);
    chk("rrmw_mem5", mem[5], w5_before);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage controller sitting directly upstream of Data_Memory: receives byte-addressed load/store requests from the execute stage and drives the word-addressed, synchronous-read data memory.
Handles byte/halfword/word sizes, sign/zero extension of loads and read-modify-write for sub-word stores, since the memory has only a full-word write.
Provides ready/busy to the pipeline hazard logic and a misalignment flag to the exception logic.

Parameters:
ADDR_WIDTH, 7, word-address width of the data memory; byte address is ADDR_WIDTH+2 bits
BIG_ENDIAN, 1, 1: byte offset k occupies bits [31-8k -: 8]; 0: bits [8k+7:8k]; halfwords follow the same rule

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present this cycle
req_write  input  1  1 store, 0 load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads only: zero-extend (lbu/lhu) instead of sign-extend
req_addr  input  ADDR_WIDTH+2  byte address
req_wdata  input  32  store data, right-justified
req_ready  output  1  high iff state==IDLE; requests are accepted only when high
resp_valid  output  1  registered one-cycle pulse: resp_rdata valid
resp_rdata  output  32  registered extended load result, holds until next load
store_done  output  1  registered one-cycle pulse: store committed
misalign  output  1  registered one-cycle pulse: request rejected
mem_address  output  ADDR_WIDTH  word address, req_addr[ADDR_WIDTH+1:2] or captured copy
mem_read  output  1  read enable to data memory
mem_write  output  1  write enable to data memory
mem_write_data  output  32  word to write
mem_read_data  input  32  memory output, valid the cycle after mem_read

Behaviour:
- States: IDLE, LOAD_WAIT, RMW. Reset: state=IDLE; resp_valid, store_done, misalign=0; resp_rdata=0; captured request registers=0.
- mem_read and mem_write are combinational from state and request, and are forced to 0 while reset is high.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00; size 11 is always rejected. On rejection in IDLE: no memory access, misalign=1 next cycle, state stays IDLE.
- Load accepted (cycle 0): mem_read=1, mem_address from req_addr; capture offset, size and unsigned; go to LOAD_WAIT.
- Cycle 1 (LOAD_WAIT): req_ready=0; extract the lane from mem_read_data and extend it; register it into resp_rdata; go to IDLE.
- Cycle 2: resp_valid=1, so load latency is 2 cycles.
- Word store accepted: mem_write=1 with req_wdata in cycle 0; state stays IDLE; store_done=1 in cycle 1. Back-to-back word stores run at 1 per cycle.
- Sub-word store accepted (cycle 0): mem_read=1; capture address, offset, size and wdata; go to RMW.
- Cycle 1 (RMW): merge the captured low byte/half into mem_read_data at its lane; mem_write=1 with the merged word at the captured address; go to IDLE.
- Cycle 2: store_done=1.
- req_valid while req_ready=0 is ignored; upstream holds the request.
- Reset in LOAD_WAIT or RMW: go to IDLE, write suppressed, memory unchanged, no resp/done pulse.
- mem_read and mem_write are never high in the same cycle.

Decomposition:
- Package load_store_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state encoding, lane-select function keyed on offset, size and BIG_ENDIAN.
- One combinational sub-module, lsu_lane_align: load extract/extend and store merge, shared by both paths.

Test Plan:
- Preload word 5 = 0x8899AABB. lw addr 0x014 -> mem_read in cycle 0, req_ready=0 in cycle 1, resp_valid with 0x8899AABB in cycle 2.
- lb addr 0x015 (BIG_ENDIAN=1) -> 0xFFFFFF99. lbu same address -> 0x00000099. lhu 0x016 -> 0x0000AABB.
- sh addr 0x016 wdata 0x00001234 -> cycle 1 mem_write with 0x88991234, store_done in cycle 2, word 5 reads back 0x88991234.
- lh 0x013, sw 0x016 and size=11 -> misalign pulse next cycle each, mem_read and mem_write stay 0, memory unchanged.
- sb 0x014 wdata 0x77 with reset asserted in the RMW cycle -> mem_write stays 0, word 5 unchanged, all outputs at reset values.
- sw 0x000=0x11111111 then sw 0x004=0x22222222 on consecutive cycles -> both written, store_done in cycles 1 and 2, req_ready stays 1.
